// File: rtl/axi_interconnect_width_convert_splitctrl_pkg.sv
// Split-command encoding shared by the address-channel splitter and the W-data sequencer.
package axi_interconnect_width_convert_splitctrl_pkg;
  localparam int CMD_LEN_W  = 8;
  localparam int CMD_OFS_W  = 8;
  localparam int CMD_SIZE_W = 3;

  localparam int CMD_TLAST_LSB = 0;
  localparam int CMD_SIZE_LSB  = CMD_TLAST_LSB + 1;
  localparam int CMD_OFS_LSB   = CMD_SIZE_LSB + CMD_SIZE_W;
  localparam int CMD_LEN_LSB   = CMD_OFS_LSB + CMD_OFS_W;
  localparam int CMD_W         = CMD_LEN_LSB + CMD_LEN_W;

  typedef struct packed {
    logic [CMD_LEN_W-1:0]  len;
    logic [CMD_OFS_W-1:0]  offset;
    logic [CMD_SIZE_W-1:0] reqsize;
    logic                  tlast;
  } split_cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction
endpackage

// File: rtl/axi_interconnect_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO; the head entry is visible while not empty.
module axi_interconnect_sync_fifo
  import axi_interconnect_width_convert_splitctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int ADDR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign pop_ok   = pop_i & ~empty_o;
  assign push_ok  = push_i & (~full_o | pop_ok);
  assign wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop_ok};
  assign rdata_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/axi_interconnect_width_convert_splitctrl.sv
// W-data sequencer for the downsizer: queues split commands and replays them beat by beat
// as lane-select / slave-word-pop / last-beat control for the W lane multiplexer.
module axi_interconnect_width_convert_splitctrl
  import axi_interconnect_width_convert_splitctrl_pkg::*;
#(
  parameter int  WIDTH_SDATA = 64,
  parameter int  WIDTH_MDATA = 32,
  parameter int  CMD_DEPTH   = 4,
  parameter int  U_DLY       = 1,
  localparam int LANES       = WIDTH_SDATA / WIDTH_MDATA,
  localparam int LANE_W      = (clog2(LANES) > 1) ? clog2(LANES) : 1,
  localparam int MAX_MSIZE   = clog2(WIDTH_MDATA / 8),
  localparam int MAX_SSIZE   = clog2(WIDTH_SDATA / 8)
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              split_en,
  input  logic [7:0]        split_len,
  input  logic [7:0]        split_offset,
  input  logic [2:0]        split_size,
  input  logic [2:0]        split_reqsize,
  input  logic              split_tlast,
  output logic              cmd_full,
  output logic              cmd_empty,
  output logic              cmd_overflow,
  output logic              seq_valid,
  input  logic              seq_ready,
  output logic [LANE_W-1:0] seq_lane,
  output logic              seq_pop,
  output logic              seq_mlast,
  output logic              seq_slast
);
  seq_state_e            state_q, state_d;
  logic [CMD_LEN_W-1:0]  beat_q, beat_d;
  logic [CMD_OFS_W-1:0]  addr_q, addr_d;
  logic [CMD_SIZE_W-1:0] size_q, size_d, head_size;
  logic                  tlast_q, tlast_d;
  logic [LANE_W-1:0]     lane_q, lane_d, lane_addr;
  logic                  pop_q, pop_d;
  logic                  mlast_q, mlast_d;
  logic                  slast_q, slast_d;
  logic                  overflow_q;
  logic [CMD_W-1:0]      cmd_wdata, cmd_rdata;
  split_cmd_t            head;
  logic                  fifo_pop, load, run_d;
  logic [CMD_OFS_W:0]    addr_ext, addr_nxt;
  logic                  unused_ok;

  // split_size is redundant with reqsize and the fixed width ratio; it is not needed here.
  assign unused_ok = ^{split_size, (U_DLY != 0)};

  assign cmd_wdata[CMD_LEN_LSB +: CMD_LEN_W]   = split_len;
  assign cmd_wdata[CMD_OFS_LSB +: CMD_OFS_W]   = split_offset;
  assign cmd_wdata[CMD_SIZE_LSB +: CMD_SIZE_W] = split_reqsize;
  assign cmd_wdata[CMD_TLAST_LSB]              = split_tlast;

  axi_interconnect_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk_sys),
    .rst_n   (rst_n),
    .push_i  (split_en),
    .wdata_i (cmd_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (cmd_rdata),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  assign head      = split_cmd_t'(cmd_rdata);
  assign head_size = (head.reqsize > CMD_SIZE_W'(MAX_MSIZE)) ? CMD_SIZE_W'(MAX_MSIZE) : head.reqsize;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    size_d   = size_q;
    tlast_d  = tlast_q;
    load     = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (seq_ready) begin
          if (beat_q != '0) begin
            beat_d = beat_q - 8'd1;
            addr_d = addr_q + (8'd1 << size_q);
          end else if (!cmd_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      fifo_pop = 1'b1;
      beat_d   = head.len;
      addr_d   = head.offset;
      size_d   = head_size;
      tlast_d  = head.tlast;
    end
  end

  if (LANES > 1) begin : g_lane
    assign lane_addr = addr_d[MAX_MSIZE +: LANE_W];
  end else begin : g_lane_single
    assign lane_addr = '0;
  end

  // Outputs are precomputed from next-state counters so they register alongside them.
  always_comb begin
    addr_ext = {1'b0, addr_d};
    addr_nxt = addr_ext + ({{CMD_OFS_W{1'b0}}, 1'b1} << size_d);
    run_d    = (state_d == ST_RUN);
    mlast_d  = run_d && (beat_d == '0);
    slast_d  = mlast_d && tlast_d;
    pop_d    = run_d && (((addr_nxt >> MAX_SSIZE) != (addr_ext >> MAX_SSIZE)) || slast_d);
    lane_d   = run_d ? lane_addr : '0;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      tlast_q    <= 1'b0;
      lane_q     <= '0;
      pop_q      <= 1'b0;
      mlast_q    <= 1'b0;
      slast_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      tlast_q <= tlast_d;
      lane_q  <= lane_d;
      pop_q   <= pop_d;
      mlast_q <= mlast_d;
      slast_q <= slast_d;
      if (split_en && cmd_full && !fifo_pop) overflow_q <= 1'b1;
    end
  end

  assign seq_valid    = (state_q == ST_RUN);
  assign seq_lane     = lane_q;
  assign seq_pop      = pop_q;
  assign seq_mlast    = mlast_q;
  assign seq_slast    = slast_q;
  assign cmd_overflow = overflow_q;
endmodule

// File: tb/tb_axi_interconnect_width_convert_splitctrl.sv
// Self-checking bench: directed and random commands scored against a queue-based beat model.
module tb_axi_interconnect_width_convert_splitctrl;
  localparam int WS     = 64;
  localparam int WM     = 32;
  localparam int DEPTH  = 4;
  localparam int SBYTES = WS / 8;
  localparam int MBYTES = WM / 8;
  localparam int LANES  = WS / WM;
  localparam int MAXM   = $clog2(MBYTES);
  localparam int MAXS   = $clog2(SBYTES);

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       split_en;
  logic [7:0] split_len;
  logic [7:0] split_offset;
  logic [2:0] split_size;
  logic [2:0] split_reqsize;
  logic       split_tlast;
  logic       cmd_full, cmd_empty, cmd_overflow;
  logic       seq_valid, seq_ready;
  logic [0:0] seq_lane;
  logic       seq_pop, seq_mlast, seq_slast;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int len;
    int ofs;
    int rs;
    bit tlast;
  } cmd_t;

  typedef struct {
    int lane;
    bit pop;
    bit mlast;
    bit slast;
  } beat_t;

  cmd_t  q_cmd[$];
  beat_t q_beat[$];
  bit    m_ovf;

  always #5 clk_sys = ~clk_sys;

  axi_interconnect_width_convert_splitctrl #(
    .WIDTH_SDATA (WS),
    .WIDTH_MDATA (WM),
    .CMD_DEPTH   (DEPTH),
    .U_DLY       (1)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .split_en      (split_en),
    .split_len     (split_len),
    .split_offset  (split_offset),
    .split_size    (split_size),
    .split_reqsize (split_reqsize),
    .split_tlast   (split_tlast),
    .cmd_full      (cmd_full),
    .cmd_empty     (cmd_empty),
    .cmd_overflow  (cmd_overflow),
    .seq_valid     (seq_valid),
    .seq_ready     (seq_ready),
    .seq_lane      (seq_lane),
    .seq_pop       (seq_pop),
    .seq_mlast     (seq_mlast),
    .seq_slast     (seq_slast)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand one command into its beats with plain byte-address arithmetic.
  task automatic expand(input cmd_t c);
    int    sz, st, a;
    beat_t b;
    sz = (c.rs > MAXM) ? MAXM : c.rs;
    st = 1 << sz;
    for (int i = 0; i <= c.len; i++) begin
      a       = (c.ofs + i * st) % 256;
      b.lane  = (a / MBYTES) % LANES;
      b.mlast = (i == c.len);
      b.slast = b.mlast && c.tlast;
      b.pop   = ((a / SBYTES) != ((a + st) / SBYTES)) || b.slast;
      q_beat.push_back(b);
    end
  endtask

  task automatic model_edge();
    bit    active, fire, last, pop, push;
    cmd_t  c;
    beat_t dummy;
    if (!rst_n) begin
      q_cmd.delete();
      q_beat.delete();
      m_ovf = 1'b0;
      return;
    end
    active = (q_beat.size() > 0);
    fire   = active && seq_ready;
    last   = fire && (q_beat.size() == 1);
    pop    = (q_cmd.size() > 0) && (!active || last);
    push   = split_en && ((q_cmd.size() < DEPTH) || pop);
    if (split_en && !push) m_ovf = 1'b1;
    if (fire) dummy = q_beat.pop_front();
    if (pop) begin
      c = q_cmd.pop_front();
      expand(c);
    end
    if (push) begin
      c.len   = int'(split_len);
      c.ofs   = int'(split_offset);
      c.rs    = int'(split_reqsize);
      c.tlast = split_tlast;
      q_cmd.push_back(c);
    end
  endtask

  task automatic compare();
    check_val("valid", 32'(seq_valid), 32'(q_beat.size() > 0));
    check_val("empty", 32'(cmd_empty), 32'(q_cmd.size() == 0));
    check_val("full", 32'(cmd_full), 32'(q_cmd.size() == DEPTH));
    check_val("overflow", 32'(cmd_overflow), 32'(m_ovf));
    if (q_beat.size() > 0) begin
      check_val("lane", 32'(seq_lane), 32'(q_beat[0].lane));
      check_val("pop", 32'(seq_pop), 32'(q_beat[0].pop));
      check_val("mlast", 32'(seq_mlast), 32'(q_beat[0].mlast));
      check_val("slast", 32'(seq_slast), 32'(q_beat[0].slast));
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    compare();
    split_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_cmd(input int len, input int ofs, input int rs, input bit tl);
    int eff;
    eff           = (rs > MAXM) ? MAXM : rs;
    split_en      = 1'b1;
    split_len     = 8'(len);
    split_offset  = 8'(ofs);
    split_reqsize = 3'(rs);
    split_size    = 3'(MAXS - eff);
    split_tlast   = tl;
    $display("cmd len=%0d ofs=%02h reqsize=%0d tlast=%0d ready=%0d", len, ofs, rs, tl, seq_ready);
    step();
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_valid"}, 32'(seq_valid), 32'd0);
    check_val({tag, "_lane"}, 32'(seq_lane), 32'd0);
    check_val({tag, "_pop"}, 32'(seq_pop), 32'd0);
    check_val({tag, "_mlast"}, 32'(seq_mlast), 32'd0);
    check_val({tag, "_slast"}, 32'(seq_slast), 32'd0);
    check_val({tag, "_empty"}, 32'(cmd_empty), 32'd1);
    check_val({tag, "_full"}, 32'(cmd_full), 32'd0);
    check_val({tag, "_overflow"}, 32'(cmd_overflow), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    split_en      = 1'b0;
    split_len     = '0;
    split_offset  = '0;
    split_size    = '0;
    split_reqsize = '0;
    split_tlast   = 1'b0;
    seq_ready     = 1'b0;
    m_ovf         = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // Aligned and odd-lane single bursts, full throughput.
    seq_ready = 1'b1;
    push_cmd(3, 8'h00, 2, 1'b1);
    idle(6);
    push_cmd(2, 8'h04, 2, 1'b1);
    idle(6);

    // Back-to-back bursts of one slave transaction.
    push_cmd(15, 8'h00, 2, 1'b0);
    push_cmd(3, 8'h00, 2, 1'b1);
    idle(25);

    // Backpressure with ready alternating.
    push_cmd(7, 8'h00, 2, 1'b1);
    for (int i = 0; i < 20; i++) begin
      seq_ready = (i % 2 == 0);
      step();
    end
    seq_ready = 1'b1;
    idle(4);

    // Address wrap through 0xFF.
    push_cmd(3, 8'hF8, 2, 1'b1);
    idle(6);

    // Overflow: fill the active slot and FIFO, then one more.
    seq_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_cmd(1, 8'h00, 2, 1'b1);
    idle(3);
    seq_ready = 1'b1;
    idle(16);

    // Narrow beats and reqsize clamp.
    push_cmd(5, 8'h03, 0, 1'b1);
    idle(10);
    push_cmd(3, 8'h00, 3, 1'b1);
    idle(6);

    // Random commands and ready.
    for (int i = 0; i < 400; i++) begin
      seq_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        push_cmd($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      else
        step();
    end
    seq_ready = 1'b1;
    idle(60);

    // Asynchronous reset in the middle of a burst with commands queued.
    push_cmd(15, 8'h00, 2, 1'b1);
    push_cmd(2, 8'h00, 2, 1'b1);
    idle(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    q_cmd.delete();
    q_beat.delete();
    m_ovf = 1'b0;
    idle(2);
    rst_n = 1'b1;
    push_cmd(3, 8'h00, 2, 1'b1);
    idle(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
